// File: rtl/taitosj_snd_pkg.sv
// Shared definitions for the sound command port transmitter.
//   snd_state_e    : command/flag sequencer states
//   Status*Bit     : bit positions inside the main-CPU status byte
//   *CycDefault    : default setup and strobe lengths in clkm_48MHZ cycles
//   cnt_inc        : 8-bit saturating increment used by the sequencer counter
package taitosj_snd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWaitAck,
        StFlagSetup,
        StFlagStrobe
    } snd_state_e;

    localparam int unsigned StatusBusyBit = 7;
    localparam int unsigned StatusFlagBit = 6;
    localparam int unsigned StatusOvfBit  = 5;

    localparam int unsigned SetupCycDefault = 4;
    localparam int unsigned PulseCycDefault = 8;

    function automatic logic [7:0] cnt_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Synchronous command FIFO, only instantiated when SND_CMD_FIFO_EN is defined.
//   clkm_48MHZ, SB2RST : clock, asynchronous active-low reset
//   push / wdata       : write request and data; dropped when full unless a pop happens too
//   pop / rdata        : read request; rdata shows the head entry (first-word fall-through)
//   full / empty       : occupancy flags
// Depth must be a power of two >= 2; pointers carry one extra wrap bit.
module sound_cmd_fifo
    import taitosj_snd_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clkm_48MHZ,
    input  logic             SB2RST,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
        if (!SB2RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clkm_48MHZ) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sound_cmd_tx.sv
// Main-CPU side transmitter for the sound command port.
//   clkm_48MHZ, SB2RST      : clock, asynchronous active-low reset
//   cpu_cmd_wr / cpu_din    : command byte write strobe and data
//   cpu_flag_wr             : NMI-enable flag write strobe (cpu_din[0])
//   snd_rd5000_n            : asynchronous sound-side latch read, acknowledges a command
//   cmd_dout                : command byte (or flag during a flag sequence) to the sound board
//   EPORT1 / EPORT2         : command / flag latch strobes, captured on the rising edge
//   cmd_busy, overflow      : command in flight / sticky dropped-command flag
//   status_out              : {cmd_busy, flag_q, overflow, 5'b0}
// Build option: define SND_CMD_FIFO_EN to queue commands in a FIFO_DEPTH-entry FIFO.
module sound_cmd_tx
    import taitosj_snd_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = SetupCycDefault,
    parameter int unsigned PULSE_CYC  = PulseCycDefault,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clkm_48MHZ,
    input  logic       SB2RST,
    input  logic       cpu_cmd_wr,
    input  logic       cpu_flag_wr,
    input  logic [7:0] cpu_din,
    input  logic       snd_rd5000_n,
    output logic [7:0] cmd_dout,
    output logic       EPORT1,
    output logic       EPORT2,
    output logic       cmd_busy,
    output logic [7:0] status_out,
    output logic       overflow
);

    if (SETUP_CYC < 1 || SETUP_CYC > 255 || PULSE_CYC < 1 || PULSE_CYC > 255 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("sound_cmd_tx: SETUP_CYC/PULSE_CYC must be 1..255, FIFO_DEPTH a power of two");
    end

    localparam logic [7:0] SetupLast = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PulseLast = 8'(PULSE_CYC - 1);

    snd_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       cmd_pend_q, cmd_pend_d;  // accepted and not yet acknowledged
    logic       cmd_sent_q, cmd_sent_d;  // EPORT1 already issued for the pending command
    logic       flag_q, flag_d;
    logic       flag_pend_q, flag_pend_d;
    logic       flag_out_q, flag_out_d;  // flag value frozen for the running flag sequence
    logic       ovf_q, ovf_d;
    logic [2:0] sync_q;                  // [1:0] synchronizer, [2] edge history
    logic       ack;

    logic       cmd_take;
    logic [7:0] cmd_src;
    logic       cmd_drop;
    logic       queue_busy;

`ifdef SND_CMD_FIFO_EN
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;

    assign cmd_take   = (state_q == StIdle) && !fifo_empty;
    assign cmd_src    = fifo_rdata;
    assign cmd_drop   = cpu_cmd_wr && fifo_full && !cmd_take;
    assign queue_busy = !fifo_empty;

    sound_cmd_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clkm_48MHZ (clkm_48MHZ),
        .SB2RST     (SB2RST),
        .push       (cpu_cmd_wr),
        .pop        (cmd_take),
        .wdata      (cpu_din),
        .rdata      (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );
`else
    // Single slot: a write is accepted whenever no command is outstanding.
    assign cmd_take   = cpu_cmd_wr && !cmd_pend_q;
    assign cmd_src    = cpu_din;
    assign cmd_drop   = cpu_cmd_wr && cmd_pend_q;
    assign queue_busy = 1'b0;
`endif

    assign ack = sync_q[2] && !sync_q[1];

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cmd_pend_d  = cmd_pend_q;
        cmd_sent_d  = cmd_sent_q;
        flag_d      = cpu_flag_wr ? cpu_din[0] : flag_q;
        flag_pend_d = flag_pend_q || cpu_flag_wr;
        flag_out_d  = flag_out_q;
        ovf_d       = ovf_q || cmd_drop;

        if (cmd_take) begin
            data_d     = cmd_src;
            cmd_pend_d = 1'b1;
            cmd_sent_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // A flag sequence goes first; a command taken alongside waits as unsent.
                if (flag_pend_d)   state_d = StFlagSetup;
                else if (cmd_take) state_d = StSetup;
            end
            StSetup: begin
                if (cnt_q >= SetupLast) state_d = StStrobe;
            end
            StStrobe: begin
                if (cnt_q >= PulseLast) begin
                    state_d    = StWaitAck;
                    cmd_sent_d = 1'b1;
                end
            end
            StWaitAck: begin
                if (ack) cmd_pend_d = 1'b0;
                if (flag_pend_d) state_d = StFlagSetup;
                else if (ack)    state_d = StIdle;
            end
            StFlagSetup, StFlagStrobe: begin
                // Still logically waiting for the sent command, so its ack is not lost.
                if (ack && cmd_pend_q && cmd_sent_q) cmd_pend_d = 1'b0;
                if (state_q == StFlagSetup) begin
                    if (cnt_q >= SetupLast) state_d = StFlagStrobe;
                end else if (cnt_q >= PulseLast) begin
                    if (cmd_pend_d && !cmd_sent_d) state_d = StSetup;
                    else if (cmd_pend_d)           state_d = StWaitAck;
                    else                           state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StFlagSetup && state_q != StFlagSetup) begin
            flag_pend_d = 1'b0;
            flag_out_d  = flag_d;
        end

        cnt_d = (state_d != state_q) ? 8'd0 : cnt_inc(cnt_q);
    end

    always_ff @(posedge clkm_48MHZ or negedge SB2RST) begin
        if (!SB2RST) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            data_q      <= 8'h00;
            cmd_pend_q  <= 1'b0;
            cmd_sent_q  <= 1'b0;
            flag_q      <= 1'b0;
            flag_pend_q <= 1'b0;
            flag_out_q  <= 1'b0;
            ovf_q       <= 1'b0;
            sync_q      <= 3'b111;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            cmd_pend_q  <= cmd_pend_d;
            cmd_sent_q  <= cmd_sent_d;
            flag_q      <= flag_d;
            flag_pend_q <= flag_pend_d;
            flag_out_q  <= flag_out_d;
            ovf_q       <= ovf_d;
            sync_q      <= {sync_q[1:0], snd_rd5000_n};
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign EPORT1   = (state_q == StStrobe);
    assign EPORT2   = (state_q == StFlagStrobe);
    assign cmd_busy = cmd_pend_q || queue_busy;
    assign overflow = ovf_q;

    always_comb begin
        if (state_q == StFlagSetup || state_q == StFlagStrobe) cmd_dout = {7'b0, flag_out_q};
        else                                                    cmd_dout = data_q;
    end

    always_comb begin
        status_out                = 8'h00;
        status_out[StatusBusyBit] = cmd_busy;
        status_out[StatusFlagBit] = flag_q;
        status_out[StatusOvfBit]  = ovf_q;
    end

endmodule
